// File: rtl/imul_iter_param.sv
// Iterative NBITS x NBITS multiplier (shift-add on magnitudes, sign fixed at the end) with val/rdy streams.
// Define IMUL_EARLY_TERM_EN to stop iterating once the remaining multiplier bits are all zero.
module imul_iter_param #(
    parameter int unsigned NBITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [2*NBITS+1:0]   istream_msg,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [NBITS-1:0]     ostream_msg
);
    localparam int unsigned W2    = 2 * NBITS;
    localparam int unsigned CNT_W = $clog2(NBITS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [W2-1:0]      a_q, a_d;
    logic [NBITS-1:0]   b_q, b_d;
    logic [W2-1:0]      prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;

    logic [1:0]         in_op;
    logic [NBITS-1:0]   in_a, in_b, a_mag, b_mag;
    logic               a_neg, b_neg, accept, last_iter;
    logic [W2-1:0]      res;

    // Request decode: signedness per op, then magnitudes of the operands
    assign in_op  = istream_msg[2*NBITS+1 -: 2];
    assign in_a   = istream_msg[2*NBITS-1 -: NBITS];
    assign in_b   = istream_msg[NBITS-1:0];
    assign a_neg  = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[NBITS-1];
    assign b_neg  = (in_op == 2'b01) && in_b[NBITS-1];
    assign a_mag  = a_neg ? (~in_a + NBITS'(1)) : in_a;
    assign b_mag  = b_neg ? (~in_b + NBITS'(1)) : in_b;
    assign accept = istream_val && istream_rdy;
    assign res    = neg_q ? (~prod_q + W2'(1)) : prod_q;

`ifdef IMUL_EARLY_TERM_EN
    assign last_iter = (cnt_q == CNT_W'(NBITS - 1)) || (b_q[NBITS-1:1] == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(NBITS - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)      state_d = CALC;
            CALC:    if (last_iter)   state_d = DONE;
            DONE:    if (ostream_rdy) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        ostream_msg = '0;
        unique case (state_q)
            IDLE: istream_rdy = ~reset;
            DONE: begin
                ostream_val = 1'b1;
                ostream_msg = (op_q == 2'b00) ? res[NBITS-1:0] : res[W2-1:NBITS];
            end
            default: ;
        endcase
    end

    // Datapath: load on accept, one shift-add step per CALC cycle
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        neg_d  = neg_q;
        if ((state_q == IDLE) && accept) begin
            a_d    = W2'(a_mag);
            b_d    = b_mag;
            prod_d = '0;
            cnt_d  = '0;
            op_d   = in_op;
            neg_d  = a_neg ^ b_neg;
        end else if (state_q == CALC) begin
            if (b_q[0]) prod_d = prod_q + a_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
        end
    end
endmodule
